// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
// Build option: DECODER_PULSE_CNT_EN adds a completed-pulse counter to the top.
package decoder_pkg;

    localparam int CNT_W     = 8;
    localparam int DEF_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        GAP   = 2'b10
    } dec_state_t;

endpackage

// File: rtl/dec_timer.sv
// Loadable down-counter shared by the DRIVE and GAP phases of the decoder.
// Clear beats load, load beats decrement; it stops at zero instead of wrapping.
module dec_timer
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_3x8_seq.sv
// Sequenced decoder: accepts a code over valid/ready and drives a one-hot pulse.
// Build option: DECODER_PULSE_CNT_EN adds output pulse_cnt (saturating count of completed pulses).
module decoder_3x8_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W       = DEF_SEL_W,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                En,
    input  logic                in_valid,
    input  logic [SEL_W-1:0]    in,
    output logic                in_ready,
    output logic [2**SEL_W-1:0] o,
    output logic                o_valid,
    output logic                busy,
`ifdef DECODER_PULSE_CNT_EN
    output logic [15:0]         pulse_cnt,
`endif
    output logic [1:0]          o_dbg_state
);

    localparam int               OUT_W   = 2**SEL_W;
    localparam bit               HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    // Handshake: a code transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on En and state, never on in_valid.
    dec_state_t       r_state;
    logic [OUT_W-1:0] r_o;
    logic             r_o_valid;

    logic             w_zero;
    logic             w_accept;
    logic             w_drive_expire;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic [OUT_W-1:0] w_onehot;

    assign in_ready       = En && (r_state == IDLE);
    assign w_accept       = in_valid && in_ready;
    assign w_drive_expire = (r_state == DRIVE) && w_zero;
    assign w_load         = w_accept || (w_drive_expire && HAS_GAP);
    assign w_load_val     = w_accept ? HOLD_LD : GAP_LD;
    assign w_dec          = (r_state != IDLE) && !w_zero;
    assign w_onehot       = OUT_W'(1) << in;

    dec_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (!En),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Dropping En wins over everything, including an expiring count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_o       <= '0;
            r_o_valid <= 1'b0;
        end else if (!En) begin
            r_state   <= IDLE;
            r_o       <= '0;
            r_o_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_o       <= w_onehot;
                        r_o_valid <= 1'b1;
                        r_state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_zero) begin
                        r_o       <= '0;
                        r_o_valid <= 1'b0;
                        if (HAS_GAP) r_state <= GAP;
                        else         r_state <= IDLE;
                    end
                end
                GAP: begin
                    if (w_zero) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DECODER_PULSE_CNT_EN
    logic [15:0] r_pulse_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= '0;
        end else if (En && w_drive_expire && (r_pulse_cnt != 16'hFFFF)) begin
            r_pulse_cnt <= r_pulse_cnt + 16'd1;
        end
    end

    assign pulse_cnt = r_pulse_cnt;
`endif

    assign o           = r_o;
    assign o_valid     = r_o_valid;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: default instance (HOLD=4, GAP=1) and minimum-timing instance (HOLD=1, GAP=0).
module tb_decoder_3x8_seq;

  localparam int HOLD0 = 4;
  localparam int GAP0  = 1;
  localparam int HOLD1 = 1;
  localparam int GAP1  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic en0 = 1'b1, vld0 = 1'b1, en1 = 1'b1, vld1 = 1'b1;
  logic [2:0] code0 = 3'd0, code1 = 3'd0;
  logic rdy0, rdy1, ov0, ov1, busy0, busy1;
  logic [7:0] o0, o1;
  logic [1:0] st0, st1;
  logic [15:0] pc0, pc1;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  // model: age = edges since accept (0 = none); pulse during 1..HOLD, gap HOLD+1..HOLD+GAP
  int age[2] = '{0, 0};
  logic [2:0] mcode[2] = '{3'd0, 3'd0};
  int mpc[2] = '{0, 0};

  always #5 clk = ~clk;

  decoder_3x8_seq #(.SEL_W(3), .HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .En(en0), .in_valid(vld0), .in(code0),
    .in_ready(rdy0), .o(o0), .o_valid(ov0), .busy(busy0),
`ifdef DECODER_PULSE_CNT_EN
    .pulse_cnt(pc0),
`endif
    .o_dbg_state(st0)
  );

  decoder_3x8_seq #(.SEL_W(3), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .En(en1), .in_valid(vld1), .in(code1),
    .in_ready(rdy1), .o(o1), .o_valid(ov1), .busy(busy1),
`ifdef DECODER_PULSE_CNT_EN
    .pulse_cnt(pc1),
`endif
    .o_dbg_state(st1)
  );

`ifndef DECODER_PULSE_CNT_EN
  assign pc0 = 16'd0;
  assign pc1 = 16'd0;
`endif

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_idle(input int a, input int h, input int g);
    return (a == 0) || (a > h + g);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        age[i] <= 0;
        mpc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int h, g;
        logic e, v;
        logic [2:0] c;
        h = (i == 0) ? HOLD0 : HOLD1;
        g = (i == 0) ? GAP0 : GAP1;
        e = (i == 0) ? en0 : en1;
        v = (i == 0) ? vld0 : vld1;
        c = (i == 0) ? code0 : code1;
        if (!e) begin
          age[i] <= 0;
        end else if (is_idle(age[i], h, g)) begin
          if (v) begin
            age[i] <= 1;
            mcode[i] <= c;
          end else begin
            age[i] <= 0;
          end
        end else begin
          if (age[i] == h && mpc[i] < 65535) mpc[i] <= mpc[i] + 1;
          age[i] <= age[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int h, g;
        logic e;
        logic [7:0] ao, eo;
        logic [1:0] es;
        h  = (i == 0) ? HOLD0 : HOLD1;
        g  = (i == 0) ? GAP0 : GAP1;
        e  = (i == 0) ? en0 : en1;
        ao = (i == 0) ? o0 : o1;
        eo = (age[i] >= 1 && age[i] <= h) ? (8'h01 << mcode[i]) : 8'h00;
        es = is_idle(age[i], h, g) ? 2'd0 : ((age[i] <= h) ? 2'd1 : 2'd2);
        chk($sformatf("o[%0d]", i), ao, eo);
        chk($sformatf("o_valid[%0d]", i), (i == 0) ? ov0 : ov1, eo != 8'h00);
        chk($sformatf("busy[%0d]", i), (i == 0) ? busy0 : busy1, !is_idle(age[i], h, g));
        chk($sformatf("in_ready[%0d]", i), (i == 0) ? rdy0 : rdy1, e && is_idle(age[i], h, g));
        chk($sformatf("state[%0d]", i), (i == 0) ? st0 : st1, es);
        chk($sformatf("onehot[%0d]", i), $countones(ao) <= 1, 1);
`ifdef DECODER_PULSE_CNT_EN
        chk($sformatf("pulse_cnt[%0d]", i), (i == 0) ? pc0 : pc1, mpc[i]);
`endif
      end
    end
  end

  // send a code on dut0, then change `in` to after_code; check nchk pulse cycles literally
  task automatic send0(input logic [2:0] k, input logic [2:0] after_code, input int nchk);
    int waited;
    logic [7:0] want;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rdy0 && waited < 30);
    if (!rdy0) chk("ready_timeout", 0, 1);
    code0 = k;
    vld0 = 1'b1;
    @(posedge clk);
    #2;
    vld0 = 1'b0;
    code0 = after_code;
    want = 8'h01 << k;
    for (int j = 0; j < nchk; j++) begin
      @(negedge clk);
      chk($sformatf("pulse_lit k=%0d cyc=%0d", k, j), o0, want);
    end
  endtask

  initial begin
    int pc_before;
    // reset with valid asserted
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rst_o", o0, 8'h00);
      chk("rst_o_valid", ov0, 0);
      chk("rst_busy", busy0, 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    vld0 = 1'b0;
    vld1 = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", rdy0, 1);
    cmp_en = 1'b1;

    // sweep of all codes back to back
    for (int k = 0; k < 8; k++) send0(3'(k), 3'($urandom_range(0, 7)), HOLD0);

    // latency/stability: in changes right after accept
    send0(3'd5, 3'd2, HOLD0);
    @(negedge clk);
    chk("after_pulse_gap", o0, 8'h00);

    // abort on second DRIVE cycle
    pc_before = pc0;
    send0(3'd7, 3'd0, 0);
    @(posedge clk);
    #2;
    en0 = 1'b0;
    @(negedge clk);
    chk("abort_pre_o", o0, 8'h80);
    @(negedge clk);
    chk("abort_o", o0, 8'h00);
    chk("abort_o_valid", ov0, 0);
    chk("abort_ready", rdy0, 0);
    chk("abort_busy", busy0, 0);
`ifdef DECODER_PULSE_CNT_EN
    chk("abort_pulse_cnt", pc0, pc_before);
`endif
    @(posedge clk);
    #2;
    en0 = 1'b1;

    // async reset in the middle of a pulse
    send0(3'd3, 3'd3, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_o", o0, 8'h00);
    chk("async_rst_o_valid", ov0, 0);
    chk("async_rst_busy", busy0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("no_resume_o", o0, 8'h00);
    end

    // minimum timing on dut1
    @(posedge clk);
    #2;
    pc_before = pc1;
    code1 = 3'd1;
    vld1 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("min_toggle cyc=%0d", j), o1, (j % 2 == 1) ? 8'h02 : 8'h00);
    end
    @(negedge clk);
`ifdef DECODER_PULSE_CNT_EN
    chk("min_pulse_cnt", pc1, pc_before + 6);
`endif
    @(posedge clk);
    #2;
    vld1 = 1'b0;

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #2;
      en0   = ($urandom_range(0, 15) != 0);
      en1   = ($urandom_range(0, 15) != 0);
      vld0  = 1'($urandom_range(0, 1));
      vld1  = 1'($urandom_range(0, 1));
      code0 = 3'($urandom_range(0, 7));
      code1 = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #2;
    vld0 = 1'b0;
    vld1 = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (8) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
